clk_div_monitor: RTL and testbench

//  Receive-side checker for the ref-domain integer clock divider output. Samples the divided clock in
//  the i_ref_clk domain, measures high/low phase and period in ref cycles, compares each period

---
 rtl/clk_div_monitor.sv | 153 +++++++++++++++
 tb/tb_clk_div_monitor.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - ref-domain phase/period checker and lock detector for an integer clock divider
module clk_div_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4
) (
    input  logic       i_ref_clk,
    input  logic       i_rst,
    input  logic       i_div_clk,
    input  logic [7:0] i_div_ratio,
    input  logic       i_en,
    input  logic       i_err_clr,
    output logic [7:0] o_high_len,
    output logic [7:0] o_low_len,
    output logic [8:0] o_period,
    output logic       o_meas_valid,
    output logic       o_lock,
    output logic       o_err,
    output logic       o_timeout,
    output logic       o_bypass
);

    typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

    localparam logic [3:0] LOCK_MAX = LOCK_CNT[3:0];

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic [7:0]             cnt;
    logic [7:0]             hi_tmp;
    logic [7:0]             r_ratio;
    logic [3:0]             good_cnt;

    logic       sync_s;
    logic       rise;
    logic       fall;
    logic       ratio_ok;
    logic [8:0] ratio_p1;
    logic [7:0] exp_high;
    logic [7:0] exp_low;
    logic       period_match;
    logic [3:0] good_inc;

    assign sync_s       = sync_q[SYNC_STAGES-1];
    assign rise         = sync_s & ~sync_d;
    assign fall         = ~sync_s & sync_d;
    assign ratio_ok     = (i_div_ratio >= 8'd2);
    // Odd ratios put the extra ref cycle in the high phase.
    assign ratio_p1     = {1'b0, r_ratio} + 9'd1;
    assign exp_high     = ratio_p1[8:1];
    assign exp_low      = {1'b0, r_ratio[7:1]};
    assign period_match = (hi_tmp == exp_high) && (cnt == exp_low);
    assign good_inc     = (good_cnt == LOCK_MAX) ? good_cnt : good_cnt + 4'd1;

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            sync_q       <= '0;
            sync_d       <= 1'b0;
            cnt          <= 8'd0;
            hi_tmp       <= 8'd0;
            r_ratio      <= 8'd0;
            good_cnt     <= 4'd0;
            o_high_len   <= 8'd0;
            o_low_len    <= 8'd0;
            o_period     <= 9'd0;
            o_meas_valid <= 1'b0;
            o_lock       <= 1'b0;
            o_err        <= 1'b0;
            o_timeout    <= 1'b0;
            o_bypass     <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], i_div_clk};
            sync_d       <= sync_s;
            o_bypass     <= ~ratio_ok;
            o_meas_valid <= 1'b0;
            o_timeout    <= 1'b0;
            // Later error assignments in this block override the clear.
            if (i_err_clr) begin
                o_err <= 1'b0;
            end

            if (state != IDLE && (!i_en || !ratio_ok)) begin
                state    <= IDLE;
                o_lock   <= 1'b0;
                good_cnt <= 4'd0;
            end else if (state != IDLE && i_div_ratio != r_ratio) begin
                r_ratio  <= i_div_ratio;
                o_lock   <= 1'b0;
                good_cnt <= 4'd0;
                state    <= WAIT_RISE;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_en && ratio_ok) begin
                            r_ratio <= i_div_ratio;
                            state   <= WAIT_RISE;
                        end
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            cnt   <= 8'd1;
                            state <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH: begin
                        if (fall) begin
                            hi_tmp <= cnt;
                            cnt    <= 8'd1;
                            state  <= MEAS_LOW;
                        end else if (cnt == 8'hFF) begin
                            o_timeout <= 1'b1;
                            o_err     <= 1'b1;
                            o_lock    <= 1'b0;
                            good_cnt  <= 4'd0;
                            state     <= WAIT_RISE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    MEAS_LOW: begin
                        if (rise) begin
                            o_high_len   <= hi_tmp;
                            o_low_len    <= cnt;
                            o_period     <= {1'b0, hi_tmp} + {1'b0, cnt};
                            o_meas_valid <= 1'b1;
                            if (period_match) begin
                                good_cnt <= good_inc;
                                o_lock   <= (good_inc == LOCK_MAX);
                            end else begin
                                good_cnt <= 4'd0;
                                o_lock   <= 1'b0;
                                o_err    <= 1'b1;
                            end
                            cnt   <= 8'd1;
                            state <= MEAS_HIGH;
                        end else if (cnt == 8'hFF) begin
                            o_timeout <= 1'b1;
                            o_err     <= 1'b1;
                            o_lock    <= 1'b0;
                            good_cnt  <= 4'd0;
                            state     <= WAIT_RISE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed self-checking bench for clk_div_monitor
module tb_clk_div_monitor;

    logic       i_ref_clk;
    logic       i_rst;
    logic       i_div_clk;
    logic [7:0] i_div_ratio;
    logic       i_en;
    logic       i_err_clr;
    logic [7:0] o_high_len;
    logic [7:0] o_low_len;
    logic [8:0] o_period;
    logic       o_meas_valid;
    logic       o_lock;
    logic       o_err;
    logic       o_timeout;
    logic       o_bypass;

    int n_checks = 0;
    int n_fail   = 0;

    // Ideal divider model state
    bit gen_on = 0;
    int ph = 0;
    int cur_hi = 0;
    int cur_lo = 0;
    int gen_hi = 0;
    int gen_lo = 0;

    int q_hi[$];
    int q_lo[$];
    int q_per[$];
    int q_lock[$];
    int n_to = 0;

    clk_div_monitor dut (
        .i_ref_clk   (i_ref_clk),
        .i_rst       (i_rst),
        .i_div_clk   (i_div_clk),
        .i_div_ratio (i_div_ratio),
        .i_en        (i_en),
        .i_err_clr   (i_err_clr),
        .o_high_len  (o_high_len),
        .o_low_len   (o_low_len),
        .o_period    (o_period),
        .o_meas_valid(o_meas_valid),
        .o_lock      (o_lock),
        .o_err       (o_err),
        .o_timeout   (o_timeout),
        .o_bypass    (o_bypass)
    );

    initial begin
        i_ref_clk = 1'b0;
        forever #5 i_ref_clk = ~i_ref_clk;
    end

    task automatic step();
        @(negedge i_ref_clk);
        if (o_meas_valid === 1'b1) begin
            q_hi.push_back(int'(o_high_len));
            q_lo.push_back(int'(o_low_len));
            q_per.push_back(int'(o_period));
            q_lock.push_back(int'(o_lock));
        end
        if (o_timeout === 1'b1) n_to++;
        if (gen_on) begin
            if (ph == 0) begin
                cur_hi = gen_hi;
                cur_lo = gen_lo;
            end
            i_div_clk = (ph < cur_hi);
            ph = (ph + 1 >= cur_hi + cur_lo) ? 0 : ph + 1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_q();
        q_hi.delete();
        q_lo.delete();
        q_per.delete();
        q_lock.delete();
    endtask

    task automatic set_gen(input int n);
        gen_hi = (n + 1) / 2;
        gen_lo = n / 2;
    endtask

    task automatic quiesce();
        i_en = 1'b0;
        gen_on = 0;
        i_div_clk = 1'b0;
        ph = 0;
        run(6);
        clear_q();
    endtask

    task automatic start(input int n);
        i_div_ratio = 8'(n);
        set_gen(n);
        i_en = 1'b1;
        run(3);
        ph = 0;
        gen_on = 1;
    endtask

    task automatic wait_ph(input int target, input string name);
        int guard = 0;
        while (ph != target && guard < 100) begin
            step();
            guard++;
        end
        n_checks++;
        if (ph != target) begin
            n_fail++;
            $display("FAIL %s: model phase %0d never reached, required %0d", name, ph, target);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        run(3);
        n_checks++;
        if ({o_high_len, o_low_len, o_period} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_lengths: got %0d/%0d/%0d required 0/0/0", o_high_len, o_low_len, o_period);
        end
        n_checks++;
        if ({o_meas_valid, o_lock, o_err, o_timeout, o_bypass} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000",
                     {o_meas_valid, o_lock, o_err, o_timeout, o_bypass});
        end
        i_rst = 1'b0;
        run(2);
    endtask

    task automatic test_n6();
        quiesce();
        start(6);
        run(60);
        n_checks++;
        if (q_per.size() < 6) begin
            n_fail++;
            $display("FAIL n6_count: got %0d measurements required >=6", q_per.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (q_hi[i] != 3 || q_lo[i] != 3 || q_per[i] != 6) begin
                    n_fail++;
                    $display("FAIL n6_meas[%0d]: got %0d/%0d/%0d required 3/3/6", i, q_hi[i], q_lo[i], q_per[i]);
                end
            end
            n_checks++;
            if (q_lock[2] != 0 || q_lock[3] != 1) begin
                n_fail++;
                $display("FAIL n6_lock: got lock %0d at 3rd, %0d at 4th, required 0 then 1", q_lock[2], q_lock[3]);
            end
        end
        n_checks++;
        if (o_err !== 1'b0 || o_bypass !== 1'b0) begin
            n_fail++;
            $display("FAIL n6_err_bypass: got err=%b bypass=%b required 0 0", o_err, o_bypass);
        end
    endtask

    task automatic test_n7();
        quiesce();
        start(7);
        run(60);
        n_checks++;
        if (q_per.size() < 5) begin
            n_fail++;
            $display("FAIL n7_count: got %0d measurements required >=5", q_per.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (q_hi[i] != 4 || q_lo[i] != 3 || q_per[i] != 7) begin
                    n_fail++;
                    $display("FAIL n7_meas[%0d]: got %0d/%0d/%0d required 4/3/7", i, q_hi[i], q_lo[i], q_per[i]);
                end
            end
        end
        n_checks++;
        if (o_err !== 1'b0 || o_lock !== 1'b1) begin
            n_fail++;
            $display("FAIL n7_status: got err=%b lock=%b required 0 1", o_err, o_lock);
        end
    endtask

    task automatic test_mismatch();
        int idx = -1;
        int guard = 0;
        quiesce();
        start(4);
        run(40);
        n_checks++;
        if (o_lock !== 1'b1) begin
            n_fail++;
            $display("FAIL mm_prelock: got lock=%b required 1", o_lock);
        end
        clear_q();
        gen_hi = 3;
        while (cur_hi != 3 && guard < 20) begin
            step();
            guard++;
        end
        gen_hi = 2;
        run(40);
        for (int i = 0; i < q_hi.size(); i++) begin
            if (idx < 0 && q_hi[i] != 2) idx = i;
        end
        n_checks++;
        if (idx < 0 || idx + 4 >= q_hi.size()) begin
            n_fail++;
            $display("FAIL mm_found: stretched period index %0d of %0d, required a stretched entry plus 4 more", idx, q_hi.size());
        end else begin
            n_checks++;
            if (q_hi[idx] != 3 || q_lo[idx] != 2 || q_per[idx] != 5 || q_lock[idx] != 0) begin
                n_fail++;
                $display("FAIL mm_bad_meas: got %0d/%0d/%0d lock %0d required 3/2/5 lock 0",
                         q_hi[idx], q_lo[idx], q_per[idx], q_lock[idx]);
            end
            n_checks++;
            if (q_lock[idx+3] != 0 || q_lock[idx+4] != 1) begin
                n_fail++;
                $display("FAIL mm_relock: got lock %0d after 3 good, %0d after 4 good, required 0 then 1",
                         q_lock[idx+3], q_lock[idx+4]);
            end
        end
        n_checks++;
        if (o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL mm_err: got err=%b required 1", o_err);
        end
    endtask

    task automatic test_timeout();
        quiesce();
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        step();
        n_checks++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_errclr: got err=%b required 0", o_err);
        end
        start(8);
        run(50);
        n_checks++;
        if (o_lock !== 1'b1) begin
            n_fail++;
            $display("FAIL to_prelock: got lock=%b required 1", o_lock);
        end
        wait_ph(2, "to_wait_high");
        gen_on = 0;
        n_to = 0;
        run(200);
        n_checks++;
        if (n_to != 0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: got %0d timeouts err=%b required 0 0", n_to, o_err);
        end
        run(100);
        n_checks++;
        if (n_to != 1 || o_err !== 1'b1 || o_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL to_fire: got %0d timeouts err=%b lock=%b required 1 1 0", n_to, o_err, o_lock);
        end
    endtask

    task automatic test_ratio_change();
        quiesce();
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        start(6);
        run(50);
        n_checks++;
        if (o_lock !== 1'b1 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rc_prelock: got lock=%b err=%b required 1 0", o_lock, o_err);
        end
        wait_ph(0, "rc_wait_period");
        clear_q();
        i_div_ratio = 8'd10;
        set_gen(10);
        step();
        run(3);
        n_checks++;
        if (o_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL rc_lock_drop: got lock=%b required 0", o_lock);
        end
        run(70);
        n_checks++;
        if (q_per.size() < 4) begin
            n_fail++;
            $display("FAIL rc_count: got %0d measurements required >=4", q_per.size());
        end else begin
            n_checks++;
            if (q_hi[0] != 5 || q_lo[0] != 5 || q_per[0] != 10) begin
                n_fail++;
                $display("FAIL rc_first: got %0d/%0d/%0d required 5/5/10", q_hi[0], q_lo[0], q_per[0]);
            end
            n_checks++;
            if (q_lock[2] != 0 || q_lock[3] != 1) begin
                n_fail++;
                $display("FAIL rc_relock: got lock %0d at 3rd, %0d at 4th, required 0 then 1", q_lock[2], q_lock[3]);
            end
        end
        n_checks++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rc_err: got err=%b required 0", o_err);
        end
    endtask

    task automatic test_bypass_reset();
        quiesce();
        i_div_ratio = 8'd1;
        gen_hi = 1;
        gen_lo = 1;
        i_en = 1'b1;
        ph = 0;
        gen_on = 1;
        run(30);
        n_checks++;
        if (o_bypass !== 1'b1 || q_per.size() != 0) begin
            n_fail++;
            $display("FAIL by_n1: got bypass=%b measurements=%0d required 1 0", o_bypass, q_per.size());
        end
        quiesce();
        start(8);
        run(50);
        n_checks++;
        if (o_lock !== 1'b1 || o_period !== 9'd8 || o_bypass !== 1'b0) begin
            n_fail++;
            $display("FAIL rs_pre: got lock=%b period=%0d bypass=%b required 1 8 0", o_lock, o_period, o_bypass);
        end
        wait_ph(5, "rs_wait_high");
        i_rst = 1'b1;
        step();
        n_checks++;
        if ({o_high_len, o_low_len, o_period} !== 25'd0) begin
            n_fail++;
            $display("FAIL rs_lengths: got %0d/%0d/%0d required 0/0/0", o_high_len, o_low_len, o_period);
        end
        n_checks++;
        if ({o_meas_valid, o_lock, o_err, o_timeout, o_bypass} !== 5'b0) begin
            n_fail++;
            $display("FAIL rs_flags: got %b required 00000", {o_meas_valid, o_lock, o_err, o_timeout, o_bypass});
        end
        i_rst = 1'b0;
        clear_q();
        run(4);
        n_checks++;
        if (q_per.size() != 0 || o_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL rs_after: got measurements=%0d lock=%b required 0 0", q_per.size(), o_lock);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_div_clk = 1'b0;
        i_div_ratio = 8'd0;
        i_en = 1'b0;
        i_err_clr = 1'b0;
        test_reset();
        test_n6();
        test_n7();
        test_mismatch();
        test_timeout();
        test_ratio_change();
        test_bypass_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
